// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_pkg
// Purpose  : Shared types and constants for the UART program loader.
//            Holds the frame-parser state encoding and the sync marker.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    ADDR      = 3'd1,
    COUNT     = 3'd2,
    DATA      = 3'd3,
    WRITE     = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_if
// Purpose  : Bundles the receiver byte handshake, the memory write port and
//            the load status lines of the UART loader.
// Ports    : master - loader side (consumes bytes, issues writes)
//            slave  - environment side (receiver, memory, core)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_loader_if;
  import uart_loader_pkg::*;

  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  modport master (
    input  rx_data, rx_data_valid, mem_ready,
    output rx_data_read, mem_addr, mem_wdata, mem_we,
           cpu_reset, load_done, load_error
  );

  modport slave (
    output rx_data, rx_data_valid, mem_ready,
    input  rx_data_read, mem_addr, mem_wdata, mem_we,
           cpu_reset, load_done, load_error
  );

endinterface
`default_nettype wire

// File: rtl/uart_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : 4-byte little-endian word assembler. The byte on byte_in is
//            placed in lane idx on every load. The word output already
//            includes the byte being loaded this cycle, so the caller can
//            capture a complete word on the same edge as the last byte.
// Ports    : aclk, reset         - clock, async active-high reset
//            load                - write byte_in into lane idx
//            idx [1:0]           - byte lane (0 = least significant)
//            byte_in [7:0]       - incoming byte
//            word [31:0]         - assembled word including current byte
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer (
  input  wire logic        aclk,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic [1:0]  idx,
  input  wire logic [7:0]  byte_in,
  output logic      [31:0] word
);

  logic [31:0] word_q;

  always_comb begin
    word = word_q;
    word[{idx, 3'b000} +: 8] = byte_in;
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      word_q <= 32'd0;
    end else if (load) begin
      word_q <= word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Purpose  : Parses frames (sync, addr, count, payload words, xor checksum)
//            from a UART byte stream into word writes and holds the core in
//            reset until a frame completes with a good checksum.
// Ports    : aclk, reset  - clock, async active-high reset
//            bus (master) - rx byte handshake, memory write port, status
// Revision : 1.0 - initial release
// ============================================================================
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_VALUE = SYNC_BYTE
) (
  input  wire logic    aclk,
  input  wire logic    reset,
  uart_loader_if.master bus
);

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [15:0] word_cnt;
  logic [7:0]  xor_acc;
  logic [31:0] mem_addr_r, mem_wdata_r;
  logic        cpu_reset_r, load_done_r, load_error_r;
  logic        rd, we, idle, sync_hit, in_field, packer_load;
  logic [31:0] packed_word;

  byte_packer u_packer (
    .aclk    (aclk),
    .reset   (reset),
    .load    (packer_load),
    .idx     (idx),
    .byte_in (bus.rx_data),
    .word    (packed_word)
  );

  always_comb begin
    rd          = 1'b0;
    we          = 1'b0;
    state_nxt   = state;
    idle        = (state == WAIT_SYNC) || (state == DONE) || (state == ERROR);
    in_field    = (state == ADDR) || (state == COUNT) || (state == DATA);
    // Every state except WRITE consumes whatever byte the receiver offers
    rd          = bus.rx_data_valid && (state != WRITE);
    we          = (state == WRITE);
    sync_hit    = idle && rd && (bus.rx_data == SYNC_VALUE);
    packer_load = rd && ((state == ADDR) || (state == DATA));

    case (state)
      WAIT_SYNC, DONE, ERROR: if (sync_hit) state_nxt = ADDR;
      ADDR:  if (rd && idx == 2'd3) state_nxt = COUNT;
      COUNT: if (rd && idx == 2'd1)
               state_nxt = ({bus.rx_data, word_cnt[7:0]} == 16'd0) ? CHECK : DATA;
      DATA:  if (rd && idx == 2'd3) state_nxt = WRITE;
      WRITE: if (bus.mem_ready) state_nxt = (word_cnt == 16'd1) ? CHECK : DATA;
      CHECK: if (rd) state_nxt = (bus.rx_data == xor_acc) ? DONE : ERROR;
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      idx          <= 2'd0;
      word_cnt     <= 16'd0;
      xor_acc      <= 8'd0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      cpu_reset_r  <= 1'b1;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      // Byte index restarts on every field boundary
      if (state_nxt != state) begin
        idx <= 2'd0;
      end else if (rd && in_field) begin
        idx <= idx + 2'd1;
      end

      if (sync_hit) begin
        xor_acc      <= 8'd0;
        cpu_reset_r  <= 1'b1;
        load_done_r  <= 1'b0;
        load_error_r <= 1'b0;
      end else if (rd && in_field) begin
        xor_acc <= xor_acc ^ bus.rx_data;
      end

      if (state == ADDR && rd && idx == 2'd3) begin
        mem_addr_r <= {packed_word[31:2], 2'b00};
      end else if (state == WRITE && bus.mem_ready) begin
        mem_addr_r <= mem_addr_r + 32'd4;
      end

      if (state == DATA && rd && idx == 2'd3) begin
        mem_wdata_r <= packed_word;
      end

      if (state == COUNT && rd) begin
        if (idx == 2'd0) word_cnt[7:0]  <= bus.rx_data;
        else             word_cnt[15:8] <= bus.rx_data;
      end else if (state == WRITE && bus.mem_ready) begin
        word_cnt <= word_cnt - 16'd1;
      end

      if (state == CHECK && rd) begin
        if (bus.rx_data == xor_acc) begin
          cpu_reset_r <= 1'b0;
          load_done_r <= 1'b1;
        end else begin
          load_error_r <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data_read = rd;
  assign bus.mem_we       = we;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_wdata    = mem_wdata_r;
  assign bus.cpu_reset    = cpu_reset_r;
  assign bus.load_done    = load_done_r;
  assign bus.load_error   = load_error_r;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Purpose  : Self-checking bench for uart_loader. Frames are built from byte
//            lists; expected writes and status come from a frame-level model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_loader;
  import uart_loader_pkg::*;

  logic aclk  = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  uart_loader_if bus ();

  uart_loader dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic force_low = 1'b0;
  logic rand_en   = 1'b0;
  int   rdcnt     = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] pw[8];

  // Memory ready driver
  always @(negedge aclk) begin
    if (force_low)    bus.mem_ready = 1'b0;
    else if (rand_en) bus.mem_ready = 1'($urandom_range(0, 1));
    else              bus.mem_ready = 1'b1;
  end

  // Write and byte-consume monitor
  always @(posedge aclk) begin
    if (!reset && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (!reset && bus.rx_data_valid && bus.rx_data_read === 1'b1) rdcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1 got = bus.rx_data_read;
      @(posedge aclk);
      if (got) break;
      @(negedge aclk);
    end
    chk("rx_accept", {31'd0, got}, 32'd1);
    #1 bus.rx_data_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge aclk);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    wait_accept();
  endtask

  // Builds a frame from addr/n/pw[], sends it and checks writes and status
  task automatic run_frame(input logic [31:0] addr, input int n, input bit corrupt);
    logic [7:0]  fb[$];
    logic [7:0]  cs;
    logic [31:0] ea;
    fb.delete();
    fb.push_back(SYNC_BYTE);
    for (int i = 0; i < 4; i++) fb.push_back(8'((addr >> (8 * i)) & 32'hFF));
    fb.push_back(8'(n & 255));
    fb.push_back(8'((n >> 8) & 255));
    for (int w = 0; w < n; w++)
      for (int i = 0; i < 4; i++) fb.push_back(8'((pw[w] >> (8 * i)) & 32'hFF));
    cs = 8'd0;
    for (int i = 1; i < fb.size(); i++) cs = cs ^ fb[i];
    if (corrupt) cs = cs ^ 8'h01;
    wa.delete();
    wd.delete();
    foreach (fb[i]) send_byte(fb[i]);
    #1;
    chk("cpu_reset_before_chk", {31'd0, bus.cpu_reset}, 32'd1);
    chk("done_before_chk", {31'd0, bus.load_done}, 32'd0);
    send_byte(cs);
    #1;
    chk("load_done", {31'd0, bus.load_done}, corrupt ? 32'd0 : 32'd1);
    chk("load_error", {31'd0, bus.load_error}, corrupt ? 32'd1 : 32'd0);
    chk("cpu_reset_after", {31'd0, bus.cpu_reset}, corrupt ? 32'd1 : 32'd0);
    chk("write_count", wa.size(), n);
    for (int w = 0; w < n; w++) begin
      ea = addr - (addr % 4) + 32'(4 * w);
      chk("wr_addr", (w < wa.size()) ? wa[w] : 32'hxxxxxxxx, ea);
      chk("wr_data", (w < wd.size()) ? wd[w] : 32'hxxxxxxxx, pw[w]);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_rd", {31'd0, bus.rx_data_read}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, bus.load_done}, 32'd0);
    chk("rst_error", {31'd0, bus.load_error}, 32'd0);
  endtask

  initial begin
    logic [7:0] sb[$];
    logic [7:0] cs;
    int rd0, n;
    bit cor;
    logic [31:0] a;

    bus.rx_data       = 8'h00;
    bus.rx_data_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge aclk);
    #1 check_reset_values();
    @(negedge aclk) reset = 1'b0;

    // Basic good frame, then same frame with a bad checksum
    pw[0] = 32'h11223344; pw[1] = 32'hAABBCCDD;
    run_frame(32'h00001000, 2, 1'b0);
    run_frame(32'h00001000, 2, 1'b1);

    // Garbage bytes discarded, then an empty frame
    rd0 = rdcnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    chk("garbage_reads", rdcnt - rd0, 3);
    run_frame(32'h12345678, 0, 1'b0);
    chk("n0_reads", rdcnt - rd0, 3 + 8);

    // Memory stall: one write held through five not-ready cycles
    force_low = 1'b1;
    wa.delete(); wd.delete();
    sb = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cs = 8'd0;
    for (int i = 1; i < sb.size(); i++) cs = cs ^ sb[i];
    foreach (sb[i]) send_byte(sb[i]);
    #1;
    bus.rx_data       = cs;
    bus.rx_data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge aclk);
        #1;
      end
      chk("stall_we", {31'd0, bus.mem_we}, 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h00002000);
      chk("stall_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("stall_rd", {31'd0, bus.rx_data_read}, 32'd0);
    end
    chk("stall_no_write", wa.size(), 0);
    force_low = 1'b0;
    wait_accept();
    #1;
    chk("stall_done", {31'd0, bus.load_done}, 32'd1);
    chk("stall_writes", wa.size(), 1);
    chk("stall_wr_addr", (wa.size() > 0) ? wa[0] : 32'hxxxxxxxx, 32'h00002000);
    chk("stall_wr_data", (wd.size() > 0) ? wd[0] : 32'hxxxxxxxx, 32'hDEADBEEF);

    // Address wrap and low-bit masking
    pw[0] = 32'hCAFEF00D; pw[1] = 32'h01020304;
    run_frame(32'hFFFFFFFC, 2, 1'b0);
    pw[0] = 32'h5A5A0F0F;
    run_frame(32'h00000003, 1, 1'b0);

    // Reset mid-payload aborts the frame
    wa.delete(); wd.delete();
    sb = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    foreach (sb[i]) send_byte(sb[i]);
    @(negedge aclk);
    bus.rx_data_valid = 1'b0;
    reset = 1'b1;
    #1 check_reset_values();
    @(negedge aclk) reset = 1'b0;
    repeat (2) @(posedge aclk);
    #1 chk("abort_no_write", wa.size(), 0);
    pw[0] = 32'h0BADF00D; pw[1] = 32'h600DCAFE;
    run_frame(32'h00003000, 2, 1'b0);

    // Random frames with random memory backpressure
    rand_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      a   = $urandom;
      n   = $urandom_range(0, 4);
      cor = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < 8; w++) pw[w] = $urandom;
      run_frame(a, n, cor);
    end
    rand_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
